// File: rtl/mul_result_queue.sv
// Multiply result queue: buffers multiplier results for the CDB and issues credits to the RS.
// Latency: 1 cycle from in_valid to out_valid on an empty queue; head fields come from registers.
// Backpressure: out_ready stalls the head; upstream is credit-limited via can_issue (no in_* backpressure).
module mul_result_queue #(
    parameter int DEPTH     = 4,
    parameter int PHY_WIDTH = 6,
    parameter int ROB_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_fire,
    output logic                 can_issue,
    input  logic                 in_valid,
    input  logic [ROB_WIDTH-1:0] in_rob_idx,
    input  logic [PHY_WIDTH-1:0] in_pd,
    input  logic [4:0]           in_rd,
    input  logic [31:0]          in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROB_WIDTH-1:0] out_rob_idx,
    output logic [PHY_WIDTH-1:0] out_pd,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_data,
    output logic                 overflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, inflight, drop_cnt;

    logic [ROB_WIDTH-1:0] mem_rob  [DEPTH];
    logic [PHY_WIDTH-1:0] mem_pd   [DEPTH];
    logic [4:0]           mem_rd   [DEPTH];
    logic [31:0]          mem_data [DEPTH];

    logic [SW-1:0] credit_sum;
    logic [SW-1:0] flush_drop;
    logic          deq, res_live, res_drop, full, enq, ovf, issue_ok, inflight_dec;

    // Credit accounting counts queued, outstanding and to-be-dropped results; registered state only.
    assign credit_sum = SW'(count) + SW'(inflight) + SW'(drop_cnt);
    assign can_issue  = credit_sum < SW'(DEPTH);

    assign out_valid   = (count != '0);
    assign out_rob_idx = mem_rob[head];
    assign out_pd      = mem_pd[head];
    assign out_rd      = mem_rd[head];
    assign out_data    = mem_data[head];

    // Per-cycle event decode: which result is kept, dropped or overflows.
    always_comb begin
        deq          = out_valid & out_ready;
        res_live     = in_valid & ~flush & (drop_cnt == '0);
        res_drop     = in_valid & ~flush & (drop_cnt != '0);
        full         = (count == CW'(DEPTH));
        enq          = res_live & (~full | deq);
        ovf          = res_live & full & ~deq;
        issue_ok     = issue_fire & can_issue & ~flush;
        // A result with nothing outstanding (credit bypassed) must not wrap the counter.
        inflight_dec = res_live & (inflight != '0);
        flush_drop   = SW'(drop_cnt) + SW'(inflight);
        if (in_valid && flush_drop != '0)
            flush_drop = flush_drop - SW'(1);
    end

    // Pointer, occupancy, credit and error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            inflight     <= '0;
            drop_cnt     <= '0;
            overflow_err <= 1'b0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= CW'(flush_drop);
        end else begin
            if (deq)
                head <= head + PW'(1);
            if (enq)
                tail <= tail + PW'(1);
            count    <= count + CW'(enq) - CW'(deq);
            inflight <= inflight + CW'(issue_ok) - CW'(inflight_dec);
            if (res_drop)
                drop_cnt <= drop_cnt - CW'(1);
            if (ovf)
                overflow_err <= 1'b1;
        end
    end

    // Entry storage, written at the tail; cleared on reset so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rob[i]  <= '0;
                mem_pd[i]   <= '0;
                mem_rd[i]   <= '0;
                mem_data[i] <= '0;
            end
        end else if (enq) begin
            mem_rob[tail]  <= in_rob_idx;
            mem_pd[tail]   <= in_pd;
            mem_rd[tail]   <= in_rd;
            mem_data[tail] <= in_data;
        end
    end
endmodule

// File: tb/tb_mul_result_queue.sv
// Bench for mul_result_queue: directed scenarios plus randomized traffic against a queue model.
// Model updates on the rising edge from the same inputs; compares happen on the falling edge.
// Checks every cycle after the first reset; literal checks pin key scenarios.
module tb_mul_result_queue;
    localparam int DEPTH = 4;

    logic        clk, rst, issue_fire, can_issue, in_valid, flush;
    logic        out_valid, out_ready, overflow_err;
    logic [4:0]  in_rob_idx, out_rob_idx, in_rd, out_rd;
    logic [5:0]  in_pd, out_pd;
    logic [31:0] in_data, out_data;

    mul_result_queue #(.DEPTH(DEPTH), .PHY_WIDTH(6), .ROB_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .issue_fire(issue_fire), .can_issue(can_issue),
        .in_valid(in_valid), .in_rob_idx(in_rob_idx), .in_pd(in_pd), .in_rd(in_rd),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rob_idx(out_rob_idx), .out_pd(out_pd), .out_rd(out_rd), .out_data(out_data),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of results plus plain integer counters.
    typedef struct {
        logic [4:0]  rob;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int   m_inflight = 0;
    int   m_drop = 0;
    bit   m_ovf = 0;

    always @(posedge clk) begin
        ent_t e;
        bit   iss;
        int   d;
        if (rst) begin
            q.delete(); m_inflight = 0; m_drop = 0; m_ovf = 0;
        end else if (flush) begin
            d = m_drop + m_inflight - (in_valid ? 1 : 0);
            m_drop = (d < 0) ? 0 : d;
            m_inflight = 0;
            q.delete();
        end else begin
            iss = issue_fire && (q.size() + m_inflight + m_drop < DEPTH);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    if (m_inflight > 0) m_inflight--;
                    if (q.size() >= DEPTH) m_ovf = 1;
                    else begin
                        e.rob = in_rob_idx; e.pd = in_pd; e.rd = in_rd; e.data = in_data;
                        q.push_back(e);
                    end
                end
            end
            if (iss) m_inflight++;
        end
    end

    // Single compare process against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("can_issue", {31'd0, can_issue},
                {31'd0, (q.size() + m_inflight + m_drop) < DEPTH});
            chk("overflow_err", {31'd0, overflow_err}, {31'd0, m_ovf});
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].data);
                chk("out_pd", {26'd0, out_pd}, {26'd0, q[0].pd});
                chk("out_rob_idx", {27'd0, out_rob_idx}, {27'd0, q[0].rob});
                chk("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
            end
        end
    end

    task automatic idle();
        rst = 0; flush = 0; issue_fire = 0; in_valid = 0;
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic do_issue();
        idle(); issue_fire = 1; tick(); idle();
    endtask
    task automatic do_result(input logic [31:0] d, input logic [5:0] pd);
        idle(); in_valid = 1; in_data = d; in_pd = pd;
        in_rob_idx = d[4:0]; in_rd = d[9:5];
        tick(); idle();
    endtask
    task automatic do_reset();
        idle(); rst = 1; tick(); idle();
    endtask

    initial begin
        idle(); out_ready = 0;
        in_rob_idx = 0; in_pd = 0; in_rd = 0; in_data = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        chk_en = 1;
        // Reset state.
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst can_issue", {31'd0, can_issue}, 32'd1);
        chk("rst overflow", {31'd0, overflow_err}, 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_pd", {26'd0, out_pd}, 32'd0);

        // Single op, one-cycle result latency.
        out_ready = 1;
        do_issue(); tick(); tick();
        do_result(32'h0000_0015, 6'd7);
        chk("single out_valid", {31'd0, out_valid}, 32'd1);
        chk("single out_data", out_data, 32'h15);
        chk("single out_pd", {26'd0, out_pd}, 32'd7);
        tick();
        chk("single drained", {31'd0, out_valid}, 32'd0);

        // Credit limit and backpressure.
        out_ready = 0;
        repeat (4) do_issue();
        chk("credit can_issue", {31'd0, can_issue}, 32'd0);
        do_issue();
        for (int i = 1; i <= 4; i++) do_result(32'h100 + i, 6'(i));
        chk("credit overflow", {31'd0, overflow_err}, 32'd0);
        repeat (5) begin
            tick();
            chk("stall out_data", out_data, 32'h101);
        end
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain order", out_data, 32'h100 + i);
            tick();
        end
        chk("drain empty", {31'd0, out_valid}, 32'd0);
        out_ready = 0;

        // Flush with 2 in flight and 1 queued.
        repeat (3) do_issue();
        do_result(32'h55, 6'd1);
        flush = 1; tick(); idle();
        chk("flush empty", {31'd0, out_valid}, 32'd0);
        do_result(32'h66, 6'd2);
        do_result(32'h77, 6'd3);
        chk("flush dropped", {31'd0, out_valid}, 32'd0);
        do_issue();
        do_result(32'h88, 6'd4);
        chk("post-flush enq", {31'd0, out_valid}, 32'd1);
        chk("post-flush data", out_data, 32'h88);
        out_ready = 1; tick(); out_ready = 0;

        // Flush coincident with a result, 2 in flight.
        repeat (2) do_issue();
        in_valid = 1; in_data = 32'h12; flush = 1; tick(); idle();
        do_result(32'h99, 6'd5);
        chk("coinc dropped", {31'd0, out_valid}, 32'd0);
        do_issue();
        do_result(32'hAA, 6'd6);
        chk("coinc kept", out_data, 32'hAA);
        out_ready = 1; tick(); out_ready = 0;

        // Forced overflow with credits bypassed.
        do_reset();
        for (int i = 0; i < 5; i++) do_result(32'h200 + i, 6'(i));
        chk("ovf flag", {31'd0, overflow_err}, 32'd1);
        chk("ovf head", out_data, 32'h200);
        tick(); tick();
        chk("ovf sticky", {31'd0, overflow_err}, 32'd1);
        do_reset();
        chk("ovf cleared", {31'd0, overflow_err}, 32'd0);
        chk("rst2 out_data", out_data, 32'd0);
        chk("rst2 can_issue", {31'd0, can_issue}, 32'd1);

        // Randomized traffic; results only arrive for outstanding ops.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 999) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            issue_fire = ($urandom_range(0, 2) != 0);
            in_valid   = ((m_inflight + m_drop) > 0) && ($urandom_range(0, 1) == 1);
            in_data    = $urandom;
            in_pd      = 6'($urandom);
            in_rob_idx = 5'($urandom);
            in_rd      = 5'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        tick();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
